// File: rtl/uart_cfg_regfile.sv
// uart_cfg_regfile: configuration/status register file for the UART controller.
// One host write port, two independent read ports (A/B), UART configuration
// outputs and a sticky error flag captured from the UART core.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data    host write port
//   rd_addr_a/rd_addr_b      read addresses (one extra bit for out-of-range)
//   rd_data_a/rd_data_b      read data (0 when out of range)
//   rd_valid_a/rd_valid_b    read address is in range
//   uart_busy/uart_error     UART status inputs (busy live, error pulse)
//   update_ok                permission to load the shadow baud rate
//   uart_enable/uart_mode    CTRL[0] / CTRL[3:1]
//   uart_rate                shadow baud-rate value driven to the UART core
module uart_cfg_regfile #(
   parameter int unsigned DATA_WIDTH   = 16,
   parameter int unsigned N_Reg        = 4,
   parameter int unsigned ADDR_WIDTH   = 2,
   parameter int unsigned READ_LATENCY = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH:0]   wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_WIDTH:0]   rd_addr_a,
   input  logic [ADDR_WIDTH:0]   rd_addr_b,
   output logic [DATA_WIDTH-1:0] rd_data_a,
   output logic [DATA_WIDTH-1:0] rd_data_b,
   output logic                  rd_valid_a,
   output logic                  rd_valid_b,
   input  logic                  uart_busy,
   input  logic                  uart_error,
   input  logic                  update_ok,
   output logic                  uart_enable,
   output logic [2:0]            uart_mode,
   output logic [15:0]           uart_rate
);

   localparam int unsigned AW = ADDR_WIDTH + 1;
   localparam int unsigned RW = 16;

   localparam logic [RW-1:0] RATE_RST = 16'd9600;
   localparam logic [AW-1:0] A_CTRL   = AW'(0);
   localparam logic [AW-1:0] A_RATE   = AW'(1);
   localparam logic [AW-1:0] A_STAT   = AW'(2);

   logic [DATA_WIDTH-1:0] ctrl_q;
   logic [RW-1:0]         rate_q;
   logic [RW-1:0]         shadow_q;
   logic                  err_q;
   logic [DATA_WIDTH-1:0] status_w;

   function automatic logic in_range(input logic [AW-1:0] a);
      return 32'(a) < N_Reg;
   endfunction

   // Register read mux; reserved and out-of-range slots return 0.
   function automatic logic [DATA_WIDTH-1:0] reg_read(
      input logic [AW-1:0]         a,
      input logic [DATA_WIDTH-1:0] c,
      input logic [RW-1:0]         r,
      input logic [DATA_WIDTH-1:0] s
   );
      logic [DATA_WIDTH-1:0] v;
      v = '0;
      if (in_range(a)) begin
         case (a)
            A_CTRL:  v = c;
            A_RATE:  v = DATA_WIDTH'(r);
            A_STAT:  v = s;
            default: v = '0;
         endcase
      end
      return v;
   endfunction

   // Write-first bypass only applies to the plain storage registers.
   function automatic logic fwd_hit(input logic [AW-1:0] a, input logic we,
                                    input logic [AW-1:0] wa);
      return we && (wa == a) && ((a == A_CTRL) || (a == A_RATE));
   endfunction

   assign status_w = DATA_WIDTH'({err_q, uart_busy});

   // Register state; error set takes priority over a same-edge W1C.
   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_q   <= '0;
         rate_q   <= RATE_RST;
         err_q    <= 1'b0;
         shadow_q <= RATE_RST;
      end else begin
         if (wr_en && (wr_addr == A_CTRL)) ctrl_q <= wr_data;
         if (wr_en && (wr_addr == A_RATE)) rate_q <= wr_data[RW-1:0];
         if (uart_error)
            err_q <= 1'b1;
         else if (wr_en && (wr_addr == A_STAT) && wr_data[1])
            err_q <= 1'b0;
         if (update_ok && !uart_busy) shadow_q <= rate_q;
      end
   end

   assign uart_enable = ctrl_q[0];
   assign uart_mode   = ctrl_q[3:1];
   assign uart_rate   = shadow_q;

   generate
      if (READ_LATENCY == 0) begin : g_comb_rd
         // Combinational read with write-first forwarding.
         always_comb begin
            rd_data_a = reg_read(rd_addr_a, ctrl_q, rate_q, status_w);
            rd_data_b = reg_read(rd_addr_b, ctrl_q, rate_q, status_w);
            if (fwd_hit(rd_addr_a, wr_en, wr_addr)) rd_data_a = wr_data;
            if (fwd_hit(rd_addr_b, wr_en, wr_addr)) rd_data_b = wr_data;
         end
         assign rd_valid_a = in_range(rd_addr_a);
         assign rd_valid_b = in_range(rd_addr_b);
      end else begin : g_reg_rd
         // Registered read-first: samples contents before this edge's write.
         always_ff @(posedge clk) begin
            if (rst) begin
               rd_data_a  <= '0;
               rd_data_b  <= '0;
               rd_valid_a <= 1'b0;
               rd_valid_b <= 1'b0;
            end else begin
               rd_data_a  <= reg_read(rd_addr_a, ctrl_q, rate_q, status_w);
               rd_data_b  <= reg_read(rd_addr_b, ctrl_q, rate_q, status_w);
               rd_valid_a <= in_range(rd_addr_a);
               rd_valid_b <= in_range(rd_addr_b);
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_uart_cfg_regfile.sv
// Self-checking bench for uart_cfg_regfile: one combinational-read instance
// and one registered-read instance driven by the same directed stimulus,
// checked every cycle against a register-map model plus literal expectations.
module tb_uart_cfg_regfile;

   localparam int unsigned DW  = 16;
   localparam int unsigned AW1 = 3;

   logic           clk = 1'b0;
   logic           rst;
   logic           wr_en;
   logic [AW1-1:0] wr_addr;
   logic [DW-1:0]  wr_data;
   logic [AW1-1:0] rd_addr_a, rd_addr_b;
   logic           uart_busy, uart_error, update_ok;

   logic [DW-1:0]  d0_data_a, d0_data_b, d1_data_a, d1_data_b;
   logic           d0_val_a, d0_val_b, d1_val_a, d1_val_b;
   logic           d0_en, d1_en;
   logic [2:0]     d0_mode, d1_mode;
   logic [15:0]    d0_rate, d1_rate;

   always #5 clk = ~clk;

   uart_cfg_regfile #(.DATA_WIDTH(DW), .N_Reg(4), .ADDR_WIDTH(2), .READ_LATENCY(0)) dut0 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_data_a(d0_data_a), .rd_data_b(d0_data_b),
      .rd_valid_a(d0_val_a), .rd_valid_b(d0_val_b),
      .uart_busy(uart_busy), .uart_error(uart_error), .update_ok(update_ok),
      .uart_enable(d0_en), .uart_mode(d0_mode), .uart_rate(d0_rate));

   uart_cfg_regfile #(.DATA_WIDTH(DW), .N_Reg(4), .ADDR_WIDTH(2), .READ_LATENCY(1)) dut1 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_data_a(d1_data_a), .rd_data_b(d1_data_b),
      .rd_valid_a(d1_val_a), .rd_valid_b(d1_val_b),
      .uart_busy(uart_busy), .uart_error(uart_error), .update_ok(update_ok),
      .uart_enable(d1_en), .uart_mode(d1_mode), .uart_rate(d1_rate));

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Model: the register map as plain variables updated per edge.
   logic [15:0] m_ctrl, m_rate, m_shadow;
   logic        m_err;
   logic [15:0] m_q_a, m_q_b;
   logic        m_qv_a, m_qv_b;
   bit          started = 1'b0;

   function automatic logic [15:0] m_read(input logic [AW1-1:0] a);
      case (a)
         3'd0:    return m_ctrl;
         3'd1:    return m_rate;
         3'd2:    return {14'd0, m_err, uart_busy};
         default: return 16'd0;
      endcase
   endfunction

   function automatic logic [15:0] m_read_now(input logic [AW1-1:0] a);
      if (wr_en && wr_addr == a && a <= 3'd1) return wr_data;
      return m_read(a);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_ctrl = 16'd0; m_rate = 16'd9600; m_shadow = 16'd9600; m_err = 1'b0;
         m_q_a = 16'd0; m_q_b = 16'd0; m_qv_a = 1'b0; m_qv_b = 1'b0;
         started = 1'b1;
      end else if (started) begin
         m_q_a  = m_read(rd_addr_a);
         m_q_b  = m_read(rd_addr_b);
         m_qv_a = rd_addr_a < 3'd4;
         m_qv_b = rd_addr_b < 3'd4;
         if (update_ok && !uart_busy) m_shadow = m_rate;
         if (uart_error) m_err = 1'b1;
         else if (wr_en && wr_addr == 3'd2 && wr_data[1]) m_err = 1'b0;
         if (wr_en && wr_addr == 3'd0) m_ctrl = wr_data;
         if (wr_en && wr_addr == 3'd1) m_rate = wr_data;
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (started) begin
         chk("c0_data_a", 32'(d0_data_a), 32'(m_read_now(rd_addr_a)));
         chk("c0_data_b", 32'(d0_data_b), 32'(m_read_now(rd_addr_b)));
         chk("c0_val_a",  32'(d0_val_a),  32'(rd_addr_a < 3'd4));
         chk("c0_val_b",  32'(d0_val_b),  32'(rd_addr_b < 3'd4));
         chk("r1_data_a", 32'(d1_data_a), 32'(m_q_a));
         chk("r1_data_b", 32'(d1_data_b), 32'(m_q_b));
         chk("r1_val_a",  32'(d1_val_a),  32'(m_qv_a));
         chk("r1_val_b",  32'(d1_val_b),  32'(m_qv_b));
         chk("c0_enable", 32'(d0_en),   32'(m_ctrl[0]));
         chk("c0_mode",   32'(d0_mode), 32'(m_ctrl[3:1]));
         chk("c0_rate",   32'(d0_rate), 32'(m_shadow));
         chk("r1_enable", 32'(d1_en),   32'(m_ctrl[0]));
         chk("r1_mode",   32'(d1_mode), 32'(m_ctrl[3:1]));
         chk("r1_rate",   32'(d1_rate), 32'(m_shadow));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [AW1-1:0] a, input logic [DW-1:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   logic [15:0] rst_vals [4];

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      rd_addr_a = '0; rd_addr_b = '0;
      uart_busy = 1'b0; uart_error = 1'b0; update_ok = 1'b0;
      tick(); tick();
      rst = 1'b0;

      // Reset contents on port A.
      rst_vals[0] = 16'd0; rst_vals[1] = 16'd9600; rst_vals[2] = 16'd0; rst_vals[3] = 16'd0;
      for (int i = 0; i < 4; i++) begin
         rd_addr_a = AW1'(i);
         @(negedge clk);
         chk("lit_rst_data", 32'(d0_data_a), 32'(rst_vals[i]));
         chk("lit_rst_valid", 32'(d0_val_a), 32'd1);
         tick();
      end
      chk("lit_rst_rate", 32'(d0_rate), 32'd9600);
      chk("lit_rst_enable", 32'(d0_en), 32'd0);

      // CTRL write and read on port B.
      wr(3'd0, 16'h000B);
      rd_addr_b = 3'd0;
      @(negedge clk);
      chk("lit_ctrl_b", 32'(d0_data_b), 32'h000B);
      chk("lit_enable", 32'(d0_en), 32'd1);
      chk("lit_mode", 32'(d0_mode), 32'd5);
      tick();

      // Same-cycle forwarding; registered port is read-first.
      rd_addr_a = 3'd0; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'd7;
      @(negedge clk);
      chk("lit_fwd", 32'(d0_data_a), 32'd7);
      tick();
      wr_en = 1'b0;
      @(negedge clk);
      chk("lit_rdfirst", 32'(d1_data_a), 32'h000B);
      chk("lit_after_wr", 32'(d0_data_a), 32'd7);
      tick();

      // Out-of-range write and reads.
      wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'h000F;
      rd_addr_a = 3'd6; rd_addr_b = 3'd7;
      @(negedge clk);
      chk("lit_oor_data", 32'(d0_data_a), 32'd0);
      chk("lit_oor_valid", 32'(d0_val_b), 32'd0);
      tick();
      wr_en = 1'b0; rd_addr_a = 3'd0; rd_addr_b = 3'd1;
      @(negedge clk);
      chk("lit_oor_ctrl", 32'(d0_data_a), 32'd7);
      chk("lit_oor_rate", 32'(d0_data_b), 32'd9600);
      tick();

      // Sticky error, W1C, and set-wins on the same edge.
      rd_addr_a = 3'd2;
      uart_error = 1'b1; tick(); uart_error = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("lit_err_sticky", 32'(d0_data_a), 32'h2);
         tick();
      end
      wr(3'd2, 16'h0002);
      @(negedge clk);
      chk("lit_err_clr", 32'(d0_data_a), 32'h0);
      tick();
      uart_error = 1'b1; wr(3'd2, 16'h0002); uart_error = 1'b0;
      @(negedge clk);
      chk("lit_err_setwins", 32'(d0_data_a), 32'h2);
      tick();
      wr(3'd2, 16'hFFFF);

      // Shadow rate gated by busy.
      wr(3'd1, 16'd4800);
      uart_busy = 1'b1; update_ok = 1'b1;
      tick(); tick();
      @(negedge clk);
      chk("lit_rate_busy", 32'(d0_rate), 32'd9600);
      chk("lit_status_busy", 32'(d0_data_a), 32'h1);
      uart_busy = 1'b0;
      tick();
      update_ok = 1'b0;
      rd_addr_a = 3'd1;
      @(negedge clk);
      chk("lit_rate_loaded", 32'(d0_rate), 32'd4800);
      chk("lit_rate_reg", 32'(d0_data_a), 32'd4800);
      tick();

      // Reserved write, then a non-write.
      wr(3'd3, 16'd1);
      rd_addr_b = 3'd3;
      @(negedge clk);
      chk("lit_rsv_rate", 32'(d0_data_a), 32'd4800);
      chk("lit_rsv_read", 32'(d0_data_b), 32'd0);
      chk("lit_rsv_valid", 32'(d0_val_b), 32'd1);
      tick();
      wr_addr = 3'd1; wr_data = 16'd1234;
      tick();
      @(negedge clk);
      chk("lit_noweren", 32'(d0_data_a), 32'd4800);
      tick();

      // Reset mid-operation beats a same-edge write.
      rst = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF; uart_error = 1'b1;
      tick();
      rst = 1'b0; wr_en = 1'b0; uart_error = 1'b0; rd_addr_a = 3'd0;
      @(negedge clk);
      chk("lit_rst_ctrl", 32'(d0_data_a), 32'd0);
      chk("lit_rst_shadow", 32'(d0_rate), 32'd9600);
      chk("lit_rst_rdvalid", 32'(d1_val_a), 32'd0);
      tick(); tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
